// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared types, latency classes and effective-latency helper
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    // Without forwarding a dependent must wait until the result has been written
    // back, so every class costs one extra cycle and ALU results cost as much as loads.
    function automatic int eff_latency(input int lat, input int max_lat, input bit fwd_en);
        int clamped;
        clamped = (lat > max_lat) ? max_lat : lat;
        if (fwd_en) begin
            return clamped;
        end
        if (lat == LAT_ALU) begin
            return LAT_LOAD + 1;
        end
        return clamped + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard_counter.sv
`default_nettype none
// ============================================================================
// scoreboard_counter : one register's latency down-counter (load / decrement)
// Revision           : 1.0
// ============================================================================
module scoreboard_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             busy_next_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o      = (cnt_q != '0);
    assign busy_next_o = (cnt_d != '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_scoreboard : latency-scoreboard stall/flush/forward control
// Revision                   : 1.0
// ============================================================================
module pipeline_hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_W      = $clog2(NUM_REGS),
    parameter int MAX_LAT    = 8,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = $clog2(MAX_LAT + 3)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid_d,
    input  logic [REG_W-1:0]                rs1_d,
    input  logic [REG_W-1:0]                rs2_d,
    input  logic                            rs1_used_d,
    input  logic                            rs2_used_d,
    input  logic [REG_W-1:0]                rd_d,
    input  logic                            reg_write_d,
    input  logic [$clog2(MAX_LAT+1)-1:0]    lat_d,
    input  logic                            branch_taken_e,
    input  logic [REG_W-1:0]                rs1_e,
    input  logic [REG_W-1:0]                rs2_e,
    input  logic [REG_W-1:0]                rd_m,
    input  logic                            reg_write_m,
    input  logic [REG_W-1:0]                rd_w,
    input  logic                            reg_write_w,
    output logic                            stall_f,
    output logic                            stall_d,
    output logic                            flush_d,
    output logic                            flush_e,
    output logic [1:0]                      forward_a_e,
    output logic [1:0]                      forward_b_e,
    output logic [$clog2(NUM_REGS+1)-1:0]   pending_count
);

    localparam int PC_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [CNT_W-1:0]    eff;
    logic                hazard;
    logic                issue_fire;
    logic [PC_W-1:0]     pending_d;
    logic [PC_W-1:0]     pending_q;
    fwd_sel_t            fwd_a;
    fwd_sel_t            fwd_b;

    assign busy[0]      = 1'b0;
    assign busy_next[0] = 1'b0;

    assign eff = CNT_W'(eff_latency(int'(lat_d), MAX_LAT, FORWARD_EN != 0));

    // The rd term is a WAW guard; it also keeps a load from colliding with a decrement.
    assign hazard = issue_valid_d && ((rs1_used_d && busy[rs1_d]) ||
                                      (rs2_used_d && busy[rs2_d]) ||
                                      (reg_write_d && busy[rd_d]));

    assign stall_d    = hazard && !branch_taken_e;
    assign stall_f    = stall_d;
    assign flush_d    = branch_taken_e;
    assign flush_e    = branch_taken_e || stall_d;
    assign issue_fire = issue_valid_d && !hazard && !branch_taken_e &&
                        reg_write_d && (rd_d != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        scoreboard_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst_n       (reset),
            .load_i      (issue_fire && (rd_d == REG_W'(r))),
            .load_val_i  (eff),
            .busy_o      (busy[r]),
            .busy_next_o (busy_next[r])
        );
    end

    // Counting next-state occupancy keeps pending_count in step with the counters.
    always_comb begin
        pending_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_d = pending_d + PC_W'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_count = pending_q;

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (FORWARD_EN != 0) begin
            if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) begin
                fwd_a = FWD_M;
            end else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) begin
                fwd_a = FWD_W;
            end
            if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) begin
                fwd_b = FWD_M;
            end else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) begin
                fwd_b = FWD_W;
            end
        end
    end

    assign forward_a_e = fwd_a;
    assign forward_b_e = fwd_b;

endmodule
`default_nettype wire
